// File: rtl/lru_stats_bcd.sv
// lru_stats_bcd: per-category LRU event counters with a once-per-frame
// snapshot, a sequential double-dabble BCD converter and a registered
// digit read port for the stats overlay renderer.
module lru_stats_bcd #(
    parameter int NUM_STATS = 8,
    parameter int CNT_W     = 11,
    parameter int DIGITS    = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_STATS-1:0] evt,
    input  logic                 clear,
    input  logic                 frame_start,
    output logic                 busy,
    output logic                 table_valid,
    output logic                 overrun,
    input  logic [2:0]           rd_stat,
    input  logic [1:0]           rd_digit,
    output logic [3:0]           rd_bcd,
    output logic                 rd_blank
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int IDX_W = (NUM_STATS > 1) ? $clog2(NUM_STATS) : 1;
    localparam int BIT_W = (CNT_W > 1) ? $clog2(CNT_W) : 1;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STATS - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(CNT_W - 1);
    localparam logic [3:0]       STAT_LIM = 4'(NUM_STATS);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_SHIFT  = 3'd2;
    localparam logic [2:0] S_STORE  = 3'd3;
    localparam logic [2:0] S_COMMIT = 3'd4;

    logic [CNT_W-1:0] r_cnt    [NUM_STATS];
    logic [CNT_W-1:0] r_snap   [NUM_STATS];
    logic [BCD_W-1:0] r_shadow [NUM_STATS];
    logic [BCD_W-1:0] r_disp   [NUM_STATS];

    logic [2:0]       r_state;
    logic [IDX_W-1:0] r_idx;
    logic [BIT_W-1:0] r_bit;
    logic [CNT_W-1:0] r_bin;
    logic [BCD_W-1:0] r_bcd;
    logic             r_busy;
    logic             r_valid;
    logic             r_overrun;
    logic [3:0]       r_rd_bcd;
    logic             r_rd_blank;

    logic [BCD_W-1:0] w_adj;
    logic             w_stat_ok;
    logic [BCD_W-1:0] w_sel;
    logic [BCD_W-1:0] w_upper;

    // Double-dabble correction: add 3 to every nibble that is 5 or more.
    function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] res;
        res = v;
        for (int k = 0; k < DIGITS; k++) begin
            if (v[4*k +: 4] >= 4'd5) begin
                res[4*k +: 4] = v[4*k +: 4] + 4'd3;
            end else begin
                res[4*k +: 4] = v[4*k +: 4];
            end
        end
        return res;
    endfunction

    assign w_adj = dd_adjust(r_bcd);

    // Live event counters: saturating, clear has priority over events.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_STATS; i++) r_cnt[i] <= '0;
        end else if (clear) begin
            for (int i = 0; i < NUM_STATS; i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_STATS; i++) begin
                if (evt[i] && (r_cnt[i] != CNT_MAX)) begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Snapshot, conversion sequencer and atomic display-table commit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_bit     <= '0;
            r_bin     <= '0;
            r_bcd     <= '0;
            r_busy    <= 1'b0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
            for (int i = 0; i < NUM_STATS; i++) begin
                r_snap[i]   <= '0;
                r_shadow[i] <= '0;
                r_disp[i]   <= '0;
            end
        end else begin
            if (frame_start && (r_state != S_IDLE)) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (frame_start) begin
                        for (int i = 0; i < NUM_STATS; i++) r_snap[i] <= r_cnt[i];
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_bin   <= r_snap[r_idx];
                    r_bcd   <= '0;
                    r_bit   <= '0;
                    r_state <= S_SHIFT;
                end
                S_SHIFT: begin
                    r_bcd <= {w_adj[BCD_W-2:0], r_bin[CNT_W-1]};
                    r_bin <= {r_bin[CNT_W-2:0], 1'b0};
                    if (r_bit == LAST_BIT) begin
                        r_state <= S_STORE;
                    end else begin
                        r_bit <= r_bit + BIT_W'(1);
                    end
                end
                S_STORE: begin
                    r_shadow[r_idx] <= r_bcd;
                    if (r_idx == LAST_IDX) begin
                        r_state <= S_COMMIT;
                    end else begin
                        r_idx   <= r_idx + IDX_W'(1);
                        r_state <= S_LOAD;
                    end
                end
                S_COMMIT: begin
                    for (int i = 0; i < NUM_STATS; i++) r_disp[i] <= r_shadow[i];
                    r_valid <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign w_stat_ok = ({1'b0, rd_stat} < STAT_LIM);
    assign w_sel     = w_stat_ok ? r_disp[rd_stat] : '0;
    assign w_upper   = w_sel >> {rd_digit, 2'b00};

    // Registered digit read port with leading-zero blanking.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_bcd   <= 4'd0;
            r_rd_blank <= 1'b1;
        end else begin
            r_rd_bcd   <= w_upper[3:0];
            r_rd_blank <= !w_stat_ok || ((rd_digit != 2'd0) && (w_upper == '0));
        end
    end

    assign busy        = r_busy;
    assign table_valid = r_valid;
    assign overrun     = r_overrun;
    assign rd_bcd      = r_rd_bcd;
    assign rd_blank    = r_rd_blank;

endmodule
